// File: rtl/mem_exibicao_pkg.sv
// Shared types for the capture-and-display buffer: FSM states and synchroniser depth.
package mem_exibicao_pkg;
  typedef enum logic [0:0] {
    VAZIO = 1'b0,
    VISTA = 1'b1
  } estado_t;

  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/mem_exibicao_nav_sincroniza_pulso.sv
// Brings an asynchronous button level into Clk and emits one pulse per rising edge.
module sincroniza_pulso
  import mem_exibicao_pkg::*;
(
  input  logic Clk,
  input  logic Rst_n,
  input  logic botao,
  output logic pulso
);
  logic [SYNC_STAGES-1:0] sinc;
  logic                   ult;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sinc <= '0;
      ult  <= 1'b0;
    end else begin
      sinc <= {sinc[SYNC_STAGES-2:0], botao};
      ult  <= sinc[SYNC_STAGES-1];
    end
  end

  // Cleared history means a button already high at reset release still yields one pulse.
  assign pulso = sinc[SYNC_STAGES-1] & ~ult;
endmodule

// File: rtl/mem_exibicao_nav.sv
// Capture buffer with button-driven forward/backward display navigation.
module mem_exibicao_nav
  import mem_exibicao_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int REPEAT = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             captura,
  input  logic [WIDTH-1:0] dado,
  input  logic             proximo,
  input  logic             anterior,
  input  logic             limpar,
  output logic [WIDTH-1:0] saida,
  output logic [AW-1:0]    indice,
  output logic [AW:0]      ocupacao,
  output logic             cheio,
  output logic             valido
);
  logic             p_prox, p_ant;
  logic [WIDTH-1:0] mem [DEPTH];
  estado_t          estado;
  logic             wr, nav;
  logic [AW-1:0]    alvo;
  logic [AW:0]      ocup_m1, prox_ext;

  sincroniza_pulso u_sinc_prox (.Clk(Clk), .Rst_n(Rst_n), .botao(proximo),  .pulso(p_prox));
  sincroniza_pulso u_sinc_ant  (.Clk(Clk), .Rst_n(Rst_n), .botao(anterior), .pulso(p_ant));

  assign cheio    = (ocupacao == (AW+1)'(DEPTH));
  assign valido   = (estado == VISTA);
  assign wr       = captura & ~cheio & ~limpar;
  assign ocup_m1  = ocupacao - 1'b1;
  assign prox_ext = {1'b0, indice} + 1'b1;

  // Target entry for this cycle's step; coincident pulses cancel out.
  always_comb begin
    nav  = 1'b0;
    alvo = indice;
    if ((p_prox ^ p_ant) && (ocupacao != '0)) begin
      if (estado == VAZIO) begin
        nav  = 1'b1;
        alvo = p_prox ? '0 : ocup_m1[AW-1:0];
      end else if (p_prox) begin
        if (prox_ext < ocupacao) begin
          nav  = 1'b1;
          alvo = prox_ext[AW-1:0];
        end else if (REPEAT != 0) begin
          nav  = 1'b1;
          alvo = '0;
        end
      end else begin
        if (indice != '0) begin
          nav  = 1'b1;
          alvo = indice - 1'b1;
        end else if (REPEAT != 0) begin
          nav  = 1'b1;
          alvo = ocup_m1[AW-1:0];
        end
      end
    end
  end

  // Storage is never reset; only entries below ocupacao are ever read.
  always_ff @(posedge Clk) begin
    if (wr) mem[ocupacao[AW-1:0]] <= dado;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ocupacao <= '0;
      saida    <= '0;
      indice   <= '0;
      estado   <= VAZIO;
    end else if (limpar) begin
      ocupacao <= '0;
      saida    <= '0;
      indice   <= '0;
      estado   <= VAZIO;
    end else begin
      if (wr) ocupacao <= ocupacao + 1'b1;
      // alvo is always below the pre-write ocupacao, so it never aliases the write slot.
      if (nav) begin
        saida  <= mem[alvo];
        indice <= alvo;
        estado <= VISTA;
      end
    end
  end
endmodule

// File: tb/tb_mem_exibicao_nav.sv
// Bench for mem_exibicao_nav: a wrapping 32x32 instance and a holding 4x16 instance share stimulus.
module tb_mem_exibicao_nav;
  logic        Clk = 1'b0;
  logic        Rst_n, captura, proximo, anterior, limpar;
  logic [31:0] dado;

  logic [31:0] saida_a;
  logic [4:0]  indice_a;
  logic [5:0]  ocupacao_a;
  logic        cheio_a, valido_a;
  logic [15:0] saida_b;
  logic [1:0]  indice_b;
  logic [2:0]  ocupacao_b;
  logic        cheio_b, valido_b;

  always #5 Clk = ~Clk;

  mem_exibicao_nav #(.WIDTH(32), .DEPTH(32), .REPEAT(1)) dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .captura(captura), .dado(dado),
    .proximo(proximo), .anterior(anterior), .limpar(limpar),
    .saida(saida_a), .indice(indice_a), .ocupacao(ocupacao_a),
    .cheio(cheio_a), .valido(valido_a));

  mem_exibicao_nav #(.WIDTH(16), .DEPTH(4), .REPEAT(0)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .captura(captura), .dado(dado[15:0]),
    .proximo(proximo), .anterior(anterior), .limpar(limpar),
    .saida(saida_b), .indice(indice_b), .ocupacao(ocupacao_b),
    .cheio(cheio_b), .valido(valido_b));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: list of captured words, a cursor and a shown flag per instance.
  int          mdepth [2] = '{32, 4};
  bit          mrep   [2] = '{1'b1, 1'b0};
  logic [31:0] mmask  [2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};
  logic [31:0] mmem   [2][32];
  int          mn     [2];
  int          mcur   [2];
  bit          mv     [2];
  logic [31:0] ms     [2];
  // Button samples taken one, two and three edges ago.
  bit hp1, hp2, hp3, ha1, ha2, ha3;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mn[i] = 0; mcur[i] = 0; mv[i] = 1'b0; ms[i] = '0;
    end
    hp1 = 0; hp2 = 0; hp3 = 0; ha1 = 0; ha2 = 0; ha3 = 0;
  endtask

  task automatic model_edge();
    bit pp, pa;
    int n, k;
    pp = hp2 & ~hp3;
    pa = ha2 & ~ha3;
    hp3 = hp2; hp2 = hp1; hp1 = proximo;
    ha3 = ha2; ha2 = ha1; ha1 = anterior;
    for (int i = 0; i < 2; i++) begin
      if (limpar) begin
        mn[i] = 0; mcur[i] = 0; mv[i] = 1'b0; ms[i] = '0;
      end else begin
        n = mn[i];
        k = -1;
        if ((pp != pa) && n > 0) begin
          if (!mv[i]) k = pp ? 0 : n - 1;
          else if (pp) k = (mcur[i] + 1 < n) ? mcur[i] + 1 : (mrep[i] ? 0 : -1);
          else k = (mcur[i] > 0) ? mcur[i] - 1 : (mrep[i] ? n - 1 : -1);
        end
        if (k >= 0) begin
          mcur[i] = k; ms[i] = mmem[i][k]; mv[i] = 1'b1;
        end
        if (captura && n < mdepth[i]) begin
          mmem[i][n] = dado & mmask[i];
          mn[i] = n + 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("saida_a",    saida_a,            ms[0]);
    chk("indice_a",   32'(indice_a),      32'(mcur[0]));
    chk("ocupacao_a", 32'(ocupacao_a),    32'(mn[0]));
    chk("cheio_a",    32'(cheio_a),       32'(mn[0] == mdepth[0]));
    chk("valido_a",   32'(valido_a),      32'(mv[0]));
    chk("saida_b",    32'(saida_b),       ms[1]);
    chk("indice_b",   32'(indice_b),      32'(mcur[1]));
    chk("ocupacao_b", 32'(ocupacao_b),    32'(mn[1]));
    chk("cheio_b",    32'(cheio_b),       32'(mn[1] == mdepth[1]));
    chk("valido_b",   32'(valido_b),      32'(mv[1]));
  endtask

  task automatic tick();
    @(posedge Clk);
    if (Rst_n) model_edge();
    else model_reset();
    #1;
    compare_all();
  endtask

  task automatic press(input int w);
    if (w == 0) proximo = 1'b1;
    else anterior = 1'b1;
    repeat (2) tick();
    proximo = 1'b0; anterior = 1'b0;
    repeat (4) tick();
  endtask

  localparam int OP_CAP = 0, OP_NXT = 1, OP_PRV = 2, OP_CLR = 3;

  typedef struct {
    int          op;
    logic [31:0] d;
    logic [31:0] sa;
    int          ia, oa;
    logic [31:0] sb;
    int          ib, ob;
    bit          cb;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int op, input logic [31:0] d, input logic [31:0] sa, input int ia,
                     input int oa, input logic [31:0] sb, input int ib, input int ob, input bit cb);
    vec_t v;
    v.op = op; v.d = d; v.sa = sa; v.ia = ia; v.oa = oa;
    v.sb = sb; v.ib = ib; v.ob = ob; v.cb = cb;
    tbl.push_back(v);
  endtask

  task automatic exec_op(input int op, input logic [31:0] d);
    case (op)
      OP_CAP: begin captura = 1'b1; dado = d; tick(); captura = 1'b0; end
      OP_CLR: begin limpar = 1'b1; tick(); limpar = 1'b0; end
      OP_NXT: press(0);
      default: press(1);
    endcase
  endtask

  initial begin
    Rst_n = 1'b1; captura = 0; proximo = 0; anterior = 0; limpar = 0; dado = '0;
    model_reset();
    #2 Rst_n = 1'b0;
    #2;
    chk("rst_saida_a",  saida_a,           32'h0);
    chk("rst_indice_a", 32'(indice_a),     32'h0);
    chk("rst_ocup_a",   32'(ocupacao_a),   32'h0);
    chk("rst_cheio_a",  32'(cheio_a),      32'h0);
    chk("rst_valido_a", 32'(valido_a),     32'h0);
    chk("rst_saida_b",  32'(saida_b),      32'h0);
    chk("rst_valido_b", 32'(valido_b),     32'h0);
    repeat (2) tick();
    Rst_n = 1'b1;

    // Wrap (A) versus hold (B) over the same three words, then depth-4 saturation.
    add(OP_CAP, 32'hA, 0, 0, 1, 0, 0, 1, 0);
    add(OP_CAP, 32'hB, 0, 0, 2, 0, 0, 2, 0);
    add(OP_CAP, 32'hC, 0, 0, 3, 0, 0, 3, 0);
    add(OP_NXT, 0, 32'hA, 0, 3, 32'hA, 0, 3, 0);
    add(OP_NXT, 0, 32'hB, 1, 3, 32'hB, 1, 3, 0);
    add(OP_NXT, 0, 32'hC, 2, 3, 32'hC, 2, 3, 0);
    add(OP_NXT, 0, 32'hA, 0, 3, 32'hC, 2, 3, 0);
    add(OP_PRV, 0, 32'hC, 2, 3, 32'hB, 1, 3, 0);
    add(OP_PRV, 0, 32'hB, 1, 3, 32'hA, 0, 3, 0);
    add(OP_PRV, 0, 32'hA, 0, 3, 32'hA, 0, 3, 0);
    add(OP_CLR, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 6; i++)
      add(OP_CAP, 32'(i), 0, 0, i, 0, 0, (i < 4) ? i : 4, i >= 4);
    for (int i = 1; i <= 5; i++)
      add(OP_NXT, 0, 32'(i), i - 1, 6, (i < 4) ? 32'(i) : 32'h4, (i < 4) ? i - 1 : 3, 4, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      exec_op(tbl[i].op, tbl[i].d);
      chk($sformatf("row%0d_saida_a", i),  saida_a,          tbl[i].sa);
      chk($sformatf("row%0d_indice_a", i), 32'(indice_a),    32'(tbl[i].ia));
      chk($sformatf("row%0d_ocup_a", i),   32'(ocupacao_a),  32'(tbl[i].oa));
      chk($sformatf("row%0d_saida_b", i),  32'(saida_b),     tbl[i].sb);
      chk($sformatf("row%0d_indice_b", i), 32'(indice_b),    32'(tbl[i].ib));
      chk($sformatf("row%0d_ocup_b", i),   32'(ocupacao_b),  32'(tbl[i].ob));
      chk($sformatf("row%0d_cheio_b", i),  32'(cheio_b),     32'(tbl[i].cb));
    end

    // Empty buffer ignores presses; a long hold steps once, on the third edge.
    exec_op(OP_CLR, 0);
    press(0);
    chk("empty_valido_a", 32'(valido_a), 32'h0);
    chk("empty_saida_a",  saida_a,       32'h0);
    exec_op(OP_CAP, 32'h55);
    exec_op(OP_CAP, 32'h66);
    proximo = 1'b1;
    tick(); chk("lat_edge1_valido", 32'(valido_a), 32'h0);
    tick(); chk("lat_edge2_valido", 32'(valido_a), 32'h0);
    tick(); chk("lat_edge3_valido", 32'(valido_a), 32'h1);
    chk("lat_edge3_saida", saida_a, 32'h55);
    repeat (17) tick();
    chk("hold_one_step_a", 32'(indice_a), 32'h0);
    chk("hold_one_step_b", 32'(indice_b), 32'h0);
    proximo = 1'b0;
    repeat (4) tick();

    // limpar wins over a same-cycle capture and step pulse.
    proximo = 1'b1;
    repeat (2) tick();
    limpar = 1'b1; captura = 1'b1; dado = 32'h77;
    tick();
    chk("clr_ocup_a",   32'(ocupacao_a), 32'h0);
    chk("clr_valido_a", 32'(valido_a),   32'h0);
    chk("clr_saida_a",  saida_a,         32'h0);
    chk("clr_ocup_b",   32'(ocupacao_b), 32'h0);
    limpar = 1'b0; captura = 1'b0; proximo = 1'b0;
    repeat (4) tick();
    chk("clr_drop_valido", 32'(valido_a), 32'h0);
    exec_op(OP_CAP, 32'h99);
    press(0);
    chk("clr_next_saida_a", saida_a,      32'h99);
    chk("clr_next_idx_a",   32'(indice_a), 32'h0);
    chk("clr_next_saida_b", 32'(saida_b), 32'h99);

    // Coincident pulses cancel.
    exec_op(OP_CAP, 32'h42);
    proximo = 1'b1; anterior = 1'b1;
    repeat (2) tick();
    proximo = 1'b0; anterior = 1'b0;
    repeat (4) tick();
    chk("both_idx_a",   32'(indice_a), 32'h0);
    chk("both_saida_a", saida_a,       32'h99);
    chk("both_saida_b", 32'(saida_b),  32'h99);

    // Asynchronous reset mid-press; a button held across release gives one pulse.
    proximo = 1'b1;
    tick();
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_saida_a",  saida_a,         32'h0);
    chk("arst_ocup_a",   32'(ocupacao_a), 32'h0);
    chk("arst_valido_a", 32'(valido_a),   32'h0);
    chk("arst_indice_a", 32'(indice_a),   32'h0);
    chk("arst_ocup_b",   32'(ocupacao_b), 32'h0);
    chk("arst_saida_b",  32'(saida_b),    32'h0);
    model_reset();
    tick();
    Rst_n = 1'b1;
    captura = 1'b1; dado = 32'h31;
    tick();
    dado = 32'h32;
    tick();
    captura = 1'b0;
    tick();
    chk("rel_pulse_valido", 32'(valido_a), 32'h1);
    chk("rel_pulse_saida",  saida_a,       32'h31);
    repeat (10) tick();
    chk("rel_single_idx", 32'(indice_a), 32'h0);
    proximo = 1'b0;
    repeat (4) tick();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      captura = ($urandom_range(2) == 0);
      dado    = $urandom;
      limpar  = ($urandom_range(99) == 0);
      if ($urandom_range(7) == 0) proximo  = ~proximo;
      if ($urandom_range(7) == 0) anterior = ~anterior;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
